// File: rtl/mdu_seq_if.sv
// Request/response bundle for the sequential multiply/divide unit.
//   master: drives start, op, a, b; observes busy, done, results, div_zero
//   slave : the unit itself
interface mdu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result_hi, result_lo, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_hi, result_lo, div_zero
    );
endinterface

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: radix-2 Booth signed multiply and
// restoring unsigned divide, one iteration per clock.
// Optional feature macro: MDU_DIV_EN (divide path, b==0 detection, div_zero).
// Without it every request is a signed multiply and div_zero is 0.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mdu_seq_if.slave: start/op/a/b in; busy/done/result_hi/result_lo/div_zero out
module mdu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    mdu_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             qm1_q, qm1_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_hi_q, result_lo_q;
    logic [WIDTH-1:0] res_hi_d, res_lo_d;
    logic             load_res_c;
    logic             accept_c;

    logic [WIDTH:0]   booth_sum_c;
    logic [WIDTH:0]   step_acc_c;
    logic [WIDTH-1:0] step_q_c;

`ifdef MDU_DIV_EN
    logic             op_q, op_d;
    logic             dz_q, dz_d;
    logic             div_zero_q;
    logic [WIDTH:0]   div_shift_c;
    logic [WIDTH:0]   div_diff_c;
`else
    logic             op_unused;
    assign op_unused = bus.op;
`endif

    // One iteration of the selected algorithm, computed from current registers
    always_comb begin
        booth_sum_c = acc_q;
        case ({q_q[0], qm1_q})
            2'b10:   booth_sum_c = acc_q - m_q;
            2'b01:   booth_sum_c = acc_q + m_q;
            default: booth_sum_c = acc_q;
        endcase
        step_acc_c = {booth_sum_c[WIDTH], booth_sum_c[WIDTH:1]};
        step_q_c   = {booth_sum_c[0], q_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        div_shift_c = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_diff_c  = div_shift_c - m_q;
        if (op_q) begin
            // Negative trial difference: keep the shifted value (restore)
            if (div_diff_c[WIDTH]) begin
                step_acc_c = div_shift_c;
                step_q_c   = {q_q[WIDTH-2:0], 1'b0};
            end else begin
                step_acc_c = div_diff_c;
                step_q_c   = {q_q[WIDTH-2:0], 1'b1};
            end
        end
`endif
    end

    // Next-state and datapath control
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        m_d        = m_q;
        q_d        = q_q;
        qm1_d      = qm1_q;
        cnt_d      = cnt_q;
        accept_c   = 1'b0;
        load_res_c = 1'b0;
        res_hi_d   = result_hi_q;
        res_lo_d   = result_lo_q;
`ifdef MDU_DIV_EN
        op_d       = op_q;
        dz_d       = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept_c = 1'b1;
                    acc_d    = '0;
                    q_d      = bus.a;
                    qm1_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
`ifdef MDU_DIV_EN
                    op_d     = bus.op;
                    dz_d     = 1'b0;
                    m_d      = bus.op ? {1'b0, bus.b} : {bus.b[WIDTH-1], bus.b};
                    if (bus.op && (bus.b == '0)) begin
                        state_d    = S_DONE;
                        dz_d       = 1'b1;
                        load_res_c = 1'b1;
                        res_hi_d   = bus.a;
                        res_lo_d   = '1;
                    end
`else
                    m_d      = {bus.b[WIDTH-1], bus.b};
`endif
                end
            end
            S_RUN: begin
                acc_d = step_acc_c;
                q_d   = step_q_c;
                qm1_d = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d    = S_DONE;
                    load_res_c = 1'b1;
                    res_hi_d   = step_acc_c[WIDTH-1:0];
                    res_lo_d   = step_q_c;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            m_q         <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_hi_q <= '0;
            result_lo_q <= '0;
`ifdef MDU_DIV_EN
            op_q        <= 1'b0;
            dz_q        <= 1'b0;
            div_zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != S_IDLE);
            // done pulses in the cycle after the DONE state
            done_q  <= (state_q == S_DONE);
            if (load_res_c) begin
                result_hi_q <= res_hi_d;
                result_lo_q <= res_lo_d;
            end
`ifdef MDU_DIV_EN
            op_q <= op_d;
            dz_q <= dz_d;
            // div_zero clears on acceptance and appears together with done
            if (accept_c) begin
                div_zero_q <= 1'b0;
            end else if (state_q == S_DONE) begin
                div_zero_q <= dz_q;
            end
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result_hi = result_hi_q;
    assign bus.result_lo = result_lo_q;
`ifdef MDU_DIV_EN
    assign bus.div_zero  = div_zero_q;
`else
    assign bus.div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq at WIDTH=8 and WIDTH=16.
module tb_mdu_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_seq_if #(.WIDTH(8))  b8();
    mdu_seq_if #(.WIDTH(16)) b16();

    mdu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    mdu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          w;
        bit          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
        int          lat;
    } vec_t;

    function automatic logic [31:0] wmask(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

    // Reference: plain arithmetic on integers
    task automatic model(input int w, input bit op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo,
                         output bit dz, output int lat);
        longint sa, sb, p;
        logic [63:0] pu;
        bit eff_op;
        eff_op = op;
`ifndef MDU_DIV_EN
        eff_op = 1'b0;
`endif
        dz  = 1'b0;
        lat = w + 1;
        if (!eff_op) begin
            sa = longint'(a);
            sb = longint'(b);
            if (a[w-1]) sa = sa - (longint'(1) << w);
            if (b[w-1]) sb = sb - (longint'(1) << w);
            p  = sa * sb;
            pu = 64'(p);
            lo = 32'(pu) & wmask(w);
            hi = 32'(pu >> w) & wmask(w);
        end else if (b == 32'd0) begin
            hi  = a;
            lo  = wmask(w);
            dz  = 1'b1;
            lat = 1;
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    task automatic set_in(input int w, input bit s, input bit o, input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin
            b8.start = s; b8.op = o; b8.a = a[7:0]; b8.b = b[7:0];
        end else begin
            b16.start = s; b16.op = o; b16.a = a[15:0]; b16.b = b[15:0];
        end
    endtask

    function automatic logic get_done(input int w);
        return (w == 8) ? b8.done : b16.done;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 8) ? b8.busy : b16.busy;
    endfunction
    function automatic logic get_dz(input int w);
        return (w == 8) ? b8.div_zero : b16.div_zero;
    endfunction
    function automatic logic [31:0] get_hi(input int w);
        return (w == 8) ? 32'(b8.result_hi) : 32'(b16.result_hi);
    endfunction
    function automatic logic [31:0] get_lo(input int w);
        return (w == 8) ? 32'(b8.result_lo) : 32'(b16.result_lo);
    endfunction

    // Issue one request; returns at the negedge of the done cycle (lat=-1 on timeout)
    task automatic run_op(input int w, input bit op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output bit dz, output int lat);
        int k;
        @(negedge clk);
        set_in(w, 1'b1, op, a, b);
        @(negedge clk);
        set_in(w, 1'b0, ~op, $urandom, $urandom);
        k = 0;
        while (get_done(w) !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        lat = (k < 100) ? k : -1;
        hi  = get_hi(w);
        lo  = get_lo(w);
        dz  = get_dz(w);
    endtask

    task automatic test_reset();
        set_in(8, 1'b0, 1'b0, 32'd0, 32'd0);
        set_in(16, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({b8.busy, b8.done, b8.div_zero, b8.result_hi, b8.result_lo} !== 19'd0)
            $display("FAIL reset_w8 got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     b8.busy, b8.done, b8.div_zero, b8.result_hi, b8.result_lo);
        else n_pass++;
        n_checks++;
        if ({b16.busy, b16.done, b16.div_zero, b16.result_hi, b16.result_lo} !== 35'd0)
            $display("FAIL reset_w16 got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     b16.busy, b16.done, b16.div_zero, b16.result_hi, b16.result_lo);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({b8.busy, b8.done, b16.busy, b16.done} !== 4'd0)
            $display("FAIL reset_idle got busy8=%b done8=%b busy16=%b done16=%b want 0",
                     b8.busy, b8.done, b16.busy, b16.done);
        else n_pass++;
    endtask

    task automatic test_directed();
        vec_t v[6];
        logic [31:0] hi, lo;
        bit dz;
        int lat;
        v[0] = '{8,  1'b0, 32'hFD,   32'h05,   32'hFF,   32'hF1, 1'b0, 9};
        v[1] = '{8,  1'b0, 32'h7F,   32'h80,   32'hC0,   32'h80, 1'b0, 9};
`ifdef MDU_DIV_EN
        v[2] = '{8,  1'b1, 32'hC8,   32'h07,   32'h04,   32'h1C, 1'b0, 9};
        v[3] = '{8,  1'b1, 32'h0D,   32'h00,   32'h0D,   32'hFF, 1'b1, 1};
`else
        v[2] = '{8,  1'b1, 32'hC8,   32'h07,   32'hFE,   32'h78, 1'b0, 9};
        v[3] = '{8,  1'b1, 32'h0D,   32'h00,   32'h00,   32'h00, 1'b0, 9};
`endif
        v[4] = '{8,  1'b0, 32'h03,   32'h04,   32'h00,   32'h0C, 1'b0, 9};
        v[5] = '{16, 1'b0, 32'h8000, 32'h8000, 32'h4000, 32'h0000, 1'b0, 17};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].w, v[i].op, v[i].a, v[i].b, hi, lo, dz, lat);
            n_checks++;
            if ({hi, lo} !== {v[i].hi, v[i].lo})
                $display("FAIL directed%0d_result got hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, v[i].hi, v[i].lo);
            else n_pass++;
            n_checks++;
            if (lat !== v[i].lat)
                $display("FAIL directed%0d_latency got %0d want %0d", i, lat, v[i].lat);
            else n_pass++;
            n_checks++;
            if (dz !== v[i].dz)
                $display("FAIL directed%0d_div_zero got %b want %b", i, dz, v[i].dz);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] hi, lo, ehi, elo, a, b;
        bit dz, edz, op;
        int lat, elat, w;
        for (int i = 0; i < 40; i++) begin
            w  = ($urandom_range(0, 1) == 0) ? 8 : 16;
            op = 1'($urandom_range(0, 1));
            a  = $urandom & wmask(w);
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom & wmask(w));
            model(w, op, a, b, ehi, elo, edz, elat);
            run_op(w, op, a, b, hi, lo, dz, lat);
            n_checks++;
            if ({hi, lo, dz, lat} !== {ehi, elo, edz, elat})
                $display("FAIL random%0d w=%0d op=%b a=%h b=%h got hi=%h lo=%h dz=%b lat=%0d want hi=%h lo=%h dz=%b lat=%0d",
                         i, w, op, a, b, hi, lo, dz, lat, ehi, elo, edz, elat);
            else n_pass++;
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] ehi, elo;
        bit edz;
        int elat, k;
        model(8, 1'b0, 32'h5A, 32'hF3, ehi, elo, edz, elat);
        @(negedge clk);
        set_in(8, 1'b1, 1'b0, 32'h5A, 32'hF3);
        @(negedge clk);
        set_in(8, 1'b0, 1'b0, 32'h00, 32'h00);
        repeat (3) @(negedge clk);
        set_in(8, 1'b1, 1'b0, 32'h11, 32'h22);
        n_checks++;
        if (b8.busy !== 1'b1) $display("FAIL busy_during_run got %b want 1", b8.busy);
        else n_pass++;
        @(negedge clk);
        set_in(8, 1'b0, 1'b0, 32'h00, 32'h00);
        k = 4;
        while (b8.done !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k !== elat) $display("FAIL ignore_latency got %0d want %0d", k, elat);
        else n_pass++;
        n_checks++;
        if ({32'(b8.result_hi), 32'(b8.result_lo)} !== {ehi, elo})
            $display("FAIL ignore_result got hi=%h lo=%h want hi=%h lo=%h", b8.result_hi, b8.result_lo, ehi, elo);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({b8.busy, b8.done} !== 2'b00)
            $display("FAIL ignore_no_queue got busy=%b done=%b want 0 0", b8.busy, b8.done);
        else n_pass++;
    endtask

    task automatic test_done_hold();
        logic [31:0] hi, lo;
        bit dz;
        int lat;
        run_op(16, 1'b0, 32'h1234, 32'hFEDC, hi, lo, dz, lat);
        @(negedge clk);
        n_checks++;
        if ({get_done(16), get_busy(16)} !== 2'b00)
            $display("FAIL done_pulse_width got done=%b busy=%b want 0 0", get_done(16), get_busy(16));
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({get_hi(16), get_lo(16)} !== {hi, lo})
            $display("FAIL result_hold got hi=%h lo=%h want hi=%h lo=%h", get_hi(16), get_lo(16), hi, lo);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] hi, lo, ehi, elo;
        bit dz, edz;
        int lat, elat;
        for (int i = 0; i < 3; i++) begin
            model(8, 1'b0, 32'(i * 37 + 5), 32'(200 - i * 13), ehi, elo, edz, elat);
            run_op(8, 1'b0, 32'(i * 37 + 5), 32'(200 - i * 13), hi, lo, dz, lat);
            n_checks++;
            if ({hi, lo, lat} !== {ehi, elo, elat})
                $display("FAIL back_to_back%0d got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                         i, hi, lo, lat, ehi, elo, elat);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] hi, lo, ehi, elo;
        bit dz, edz;
        int lat, elat, pulses;
        run_op(8, 1'b0, 32'h0D, 32'h05, hi, lo, dz, lat);
        @(negedge clk);
        set_in(8, 1'b1, 1'b0, 32'h77, 32'h99);
        @(negedge clk);
        set_in(8, 1'b0, 1'b0, 32'h00, 32'h00);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({b8.busy, b8.done, b8.div_zero, b8.result_hi, b8.result_lo} !== 19'd0)
            $display("FAIL reset_mid_run got busy=%b done=%b dz=%b hi=%h lo=%h want all 0",
                     b8.busy, b8.done, b8.div_zero, b8.result_hi, b8.result_lo);
        else n_pass++;
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (b8.done === 1'b1 || b8.busy === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL reset_no_done got %0d active cycles want 0", pulses);
        else n_pass++;
        model(8, 1'b0, 32'h6B, 32'hC4, ehi, elo, edz, elat);
        run_op(8, 1'b0, 32'h6B, 32'hC4, hi, lo, dz, lat);
        n_checks++;
        if ({hi, lo, lat} !== {ehi, elo, elat})
            $display("FAIL after_reset_op got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                     hi, lo, lat, ehi, elo, elat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_done_hold();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mdu_seq.md
# mdu_seq

Parametrised sequential multiply/divide unit: one shift-add datapath and its controlling FSM in a single block, generalised to any operand width. Radix-2 Booth signed multiplication and restoring unsigned division, one iteration per clock, with a start/busy/done handshake and divide-by-zero detection. Sits beside the single-cycle add/sub path inside the ALU. The top-level op decode routes mul/div requests here.

## Interface
- WIDTH, 8, operand width in bits; legal range 4..32.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  1  0 = signed multiply, 1 = unsigned divide.
- a  in  WIDTH  multiplicand / dividend, captured at the accepting edge.
- b  in  WIDTH  multiplier / divisor, captured at the accepting edge.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- result_hi  out  WIDTH  multiply: product[2W-1:W]; divide: remainder.
- result_lo  out  WIDTH  multiply: product[W-1:0]; divide: quotient.
- div_zero  out  1  set with done when a divide had b == 0; cleared at the next accepted start.

## Operation
- Registers:
  - A: WIDTH+1 bits, sign-extended.
  - M: WIDTH+1 bits. Multiply: sign-extended b. Divide: zero-extended b.
  - Q: WIDTH bits.
  - q_m1: 1 bit, Booth history.
  - cnt: $clog2(WIDTH)+1 bits.
- States: IDLE, RUN, DONE.
- IDLE, start=1: capture Q=a and M as above, clear A, q_m1 and cnt, clear div_zero, latch op, go to RUN.
- Exception: op=1 with b==0 goes directly to DONE. That path loads result_lo = all ones, result_hi = a, and sets div_zero=1.
- RUN, multiply step:
  - If {Q[0],q_m1}=10: A=A-M. If 01: A=A+M. Otherwise A is unchanged.
  - Then arithmetic right shift of {A,Q,q_m1} by one.
- RUN, divide step:
  - Shift {A,Q} left by one, then A=A-M.
  - If A is negative: Q[0]=0 and A is restored (A+M). Otherwise Q[0]=1.
- cnt increments every RUN cycle. When cnt == WIDTH-1, the last step completes on that edge and the state goes to DONE.
- DONE: done=1 for exactly one cycle. On the edge entering DONE, result_hi<=A[WIDTH-1:0] and result_lo<=Q. The state then returns to IDLE.
- result_hi, result_lo and div_zero hold their values until the next DONE. Outputs never show intermediate values.
- start while busy is ignored; no queuing.
- a, b and op may change freely after the accepting edge.

## Timing
- Reset values: state IDLE; busy=0, done=0, result_hi=0, result_lo=0, div_zero=0; all internal registers 0.
- Normal latency: start accepted at edge 0, done is high in the cycle after edge WIDTH+1.
- Divide-by-zero latency: done is high in the cycle after edge 1.
- busy rises after edge 0 and falls after the DONE cycle. Back-to-back: start may be reasserted in the first IDLE cycle after done.
- Reset asserted mid-RUN or in DONE: immediate return to IDLE, all outputs zero, no done pulse, the partial result is discarded.
- Reset release must be synchronised externally; the block needs no internal synchroniser.

## Configuration
- MDU_DIV_EN defined: divide path, b==0 detection and div_zero as specified above.
- MDU_DIV_EN undefined:
  - Divide logic is removed.
  - op is ignored and every request is a signed multiply.
  - div_zero is tied to 0.

## Test plan
- WIDTH=8, op=0, a=-3 (0xFD), b=5 -> done after 9 edges; {result_hi,result_lo}=16'hFFF1, div_zero=0.
- WIDTH=8, op=0, a=127, b=-128 (0x80) -> {result_hi,result_lo}=16'hC080 (-16256). Checks the extended-A corner.
- WIDTH=8, op=1, a=200, b=7 -> result_lo=0x1C, result_hi=0x04, done 9 edges after start.
- WIDTH=8, op=1, a=13, b=0 -> done 1 edge after start; result_lo=0xFF, result_hi=0x0D, div_zero=1. A following valid start clears div_zero.
- Pulse start again at RUN cycle 3 of a multiply -> ignored, first result unaffected. Assert rst_n=0 at RUN cycle 5 -> busy, done and results are 0 immediately, state IDLE.
- WIDTH=16, op=0, a=-32768, b=-32768 -> {hi,lo}=32'h40000000 after 17 edges.
